// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle: memory-stage beat plus stall/flush in, writeback and PC-load results out.
// The master side drives the beat; the slave side (the stage) returns registered results.
interface mem_wb_stage_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
);
    logic                    stall;
    logic                    flush;
    logic                    in_valid;
    logic [DATA_W-1:0]       alu_data_in;
    logic [DATA_W-1:0]       mem_data_in;
    logic                    mem_read_in;
    logic                    wb_in;
    logic [REG_ADDR_W-1:0]   rdst_in;
    logic                    write_flag_in;
    logic                    write_pc_high_in;
    logic                    write_pc_low_in;
    logic                    in_inst_in;
    logic                    out_inst_in;

    logic                    wb_valid;
    logic                    wb_en;
    logic [REG_ADDR_W-1:0]   wb_rdst;
    logic [DATA_W-1:0]       wb_data;
    logic                    write_flag_out;
    logic                    in_inst_out;
    logic                    out_inst_out;
    logic                    pc_load;
    logic [2*DATA_W-1:0]     pc_value;
    logic                    pc_seq_err;
`ifdef MEM_WB_BYPASS_EN
    logic                    fwd_en;
    logic [REG_ADDR_W-1:0]   fwd_rdst;
    logic [DATA_W-1:0]       fwd_data;
`endif

    modport master (
        output stall, flush, in_valid, alu_data_in, mem_data_in, mem_read_in, wb_in, rdst_in,
               write_flag_in, write_pc_high_in, write_pc_low_in, in_inst_in, out_inst_in,
        input  wb_valid, wb_en, wb_rdst, wb_data, write_flag_out, in_inst_out, out_inst_out,
               pc_load, pc_value, pc_seq_err
`ifdef MEM_WB_BYPASS_EN
        , input fwd_en, fwd_rdst, fwd_data
`endif
    );

    modport slave (
        input  stall, flush, in_valid, alu_data_in, mem_data_in, mem_read_in, wb_in, rdst_in,
               write_flag_in, write_pc_high_in, write_pc_low_in, in_inst_in, out_inst_in,
        output wb_valid, wb_en, wb_rdst, wb_data, write_flag_out, in_inst_out, out_inst_out,
               pc_load, pc_value, pc_seq_err
`ifdef MEM_WB_BYPASS_EN
        , output fwd_en, fwd_rdst, fwd_data
`endif
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback mux and 2-beat PC restore; MEM_WB_BYPASS_EN adds forwarding outputs.
// Latency: 1 cycle from accepted beat to wb_* / pc_load / pc_seq_err.
// Backpressure: stall holds every register (pulses drop to 0); flush inserts a bubble and wins over stall.
module mem_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);
    typedef enum logic {IDLE, HAVE_HIGH} pc_state_t;

    pc_state_t          state, state_nxt;
    logic [DATA_W-1:0]  sel_data;
    logic [DATA_W-1:0]  hi_reg;
    logic               accept;
    logic               load_nxt, err_nxt, hi_wr, pc_wr;

    assign sel_data = bus.mem_read_in ? bus.mem_data_in : bus.alu_data_in;
    assign accept   = !rst && !bus.flush && !bus.stall && bus.in_valid;

    // Only accepted beats move the sequencer; bubbles and non-PC beats leave it alone.
    always_comb begin
        state_nxt = state;
        load_nxt  = 1'b0;
        err_nxt   = 1'b0;
        hi_wr     = 1'b0;
        pc_wr     = 1'b0;
        if (accept) begin
            if (bus.write_pc_high_in && bus.write_pc_low_in) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end else if (bus.write_pc_high_in) begin
                hi_wr     = 1'b1;
                err_nxt   = (state == HAVE_HIGH);
                state_nxt = HAVE_HIGH;
            end else if (bus.write_pc_low_in) begin
                if (state == HAVE_HIGH) begin
                    pc_wr     = 1'b1;
                    load_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    err_nxt   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            hi_reg             <= '0;
            bus.wb_valid       <= 1'b0;
            bus.wb_en          <= 1'b0;
            bus.wb_rdst        <= '0;
            bus.wb_data        <= '0;
            bus.write_flag_out <= 1'b0;
            bus.in_inst_out    <= 1'b0;
            bus.out_inst_out   <= 1'b0;
            bus.pc_load        <= 1'b0;
            bus.pc_value       <= '0;
            bus.pc_seq_err     <= 1'b0;
        end else if (bus.flush) begin
            // Data and destination are don't-care under a bubble, so they simply hold.
            state              <= IDLE;
            bus.wb_valid       <= 1'b0;
            bus.wb_en          <= 1'b0;
            bus.write_flag_out <= 1'b0;
            bus.in_inst_out    <= 1'b0;
            bus.out_inst_out   <= 1'b0;
            bus.pc_load        <= 1'b0;
            bus.pc_seq_err     <= 1'b0;
        end else if (bus.stall) begin
            bus.pc_load        <= 1'b0;
            bus.pc_seq_err     <= 1'b0;
        end else begin
            state              <= state_nxt;
            bus.wb_valid       <= bus.in_valid;
            bus.wb_en          <= bus.wb_in && bus.in_valid;
            bus.wb_rdst        <= bus.rdst_in;
            bus.wb_data        <= sel_data;
            bus.write_flag_out <= bus.write_flag_in && bus.in_valid;
            bus.in_inst_out    <= bus.in_inst_in && bus.in_valid;
            bus.out_inst_out   <= bus.out_inst_in && bus.in_valid;
            bus.pc_load        <= load_nxt;
            bus.pc_seq_err     <= err_nxt;
            if (hi_wr) hi_reg       <= sel_data;
            if (pc_wr) bus.pc_value <= {hi_reg, sel_data};
        end
    end

`ifdef MEM_WB_BYPASS_EN
    assign bus.fwd_en   = bus.wb_en;
    assign bus.fwd_rdst = bus.wb_rdst;
    assign bus.fwd_data = bus.wb_data;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, then randomized beats against a behavioural model.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;

    mem_wb_stage_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();
    mem_wb_stage #(.DATA_W(16), .REG_ADDR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, stall, flush, in_valid;
        logic [15:0] alu, mem;
        logic        mr, wb;
        logic [2:0]  rdst;
        logic        wf, hi, lo, inn, outn;
    } beat_t;

    typedef struct packed {
        logic        valid, en;
        logic [2:0]  rdst;
        logic [15:0] data;
        logic        wf, inn, outn, load;
        logic [31:0] pc;
        logic        err;
    } out_t;

    typedef struct {
        beat_t b;
        out_t  e;
    } vec_t;

    vec_t tv[$];

    // Reference model state: a pending high half is just a flag plus its value.
    out_t        m;
    bit          m_have_hi;
    logic [15:0] m_hi;

    function automatic beat_t mkb(logic s, logic f, logic v, logic [15:0] alu, logic [15:0] mem,
                                  logic mr, logic wb, logic [2:0] rdst, logic wf, logic hi,
                                  logic lo, logic inn, logic outn);
        beat_t b;
        b = '{1'b0, s, f, v, alu, mem, mr, wb, rdst, wf, hi, lo, inn, outn};
        return b;
    endfunction

    function automatic out_t mko(logic v, logic en, logic [2:0] rdst, logic [15:0] data,
                                 logic wf, logic inn, logic outn, logic load, logic [31:0] pc,
                                 logic err);
        out_t o;
        o = '{v, en, rdst, data, wf, inn, outn, load, pc, err};
        return o;
    endfunction

    function automatic out_t get_out();
        out_t o;
        o = '{bus.wb_valid, bus.wb_en, bus.wb_rdst, bus.wb_data, bus.write_flag_out,
              bus.in_inst_out, bus.out_inst_out, bus.pc_load, bus.pc_value, bus.pc_seq_err};
        return o;
    endfunction

    task automatic drive(input beat_t b);
        rst                  = b.rst;
        bus.stall            = b.stall;
        bus.flush            = b.flush;
        bus.in_valid         = b.in_valid;
        bus.alu_data_in      = b.alu;
        bus.mem_data_in      = b.mem;
        bus.mem_read_in      = b.mr;
        bus.wb_in            = b.wb;
        bus.rdst_in          = b.rdst;
        bus.write_flag_in    = b.wf;
        bus.write_pc_high_in = b.hi;
        bus.write_pc_low_in  = b.lo;
        bus.in_inst_in       = b.inn;
        bus.out_inst_in      = b.outn;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic model_step(input beat_t b);
        logic [15:0] sel;
        sel = b.mr ? b.mem : b.alu;
        if (b.rst) begin
            m = '0;
            m_have_hi = 0;
            m_hi = '0;
        end else if (b.flush) begin
            m.valid = 0; m.en = 0; m.wf = 0; m.inn = 0; m.outn = 0; m.load = 0; m.err = 0;
            m_have_hi = 0;
        end else if (b.stall) begin
            m.load = 0;
            m.err  = 0;
        end else begin
            m.valid = b.in_valid;
            m.en    = b.wb & b.in_valid;
            m.rdst  = b.rdst;
            m.data  = sel;
            m.wf    = b.wf & b.in_valid;
            m.inn   = b.inn & b.in_valid;
            m.outn  = b.outn & b.in_valid;
            m.load  = 0;
            m.err   = 0;
            if (b.in_valid) begin
                if (b.hi && b.lo) begin
                    m.err = 1;
                    m_have_hi = 0;
                end else if (b.hi) begin
                    m.err = m_have_hi;
                    m_hi = sel;
                    m_have_hi = 1;
                end else if (b.lo) begin
                    if (m_have_hi) begin
                        m.pc = {m_hi, sel};
                        m.load = 1;
                        m_have_hi = 0;
                    end else begin
                        m.err = 1;
                    end
                end
            end
        end
    endtask

    function automatic beat_t rand_beat(int rst_pct, int stall_pct, int flush_pct);
        beat_t b;
        b.rst      = ($urandom_range(99) < rst_pct);
        b.stall    = ($urandom_range(99) < stall_pct);
        b.flush    = ($urandom_range(99) < flush_pct);
        b.in_valid = ($urandom_range(3) != 0);
        b.alu      = 16'($urandom);
        b.mem      = 16'($urandom);
        b.mr       = 1'($urandom);
        b.wb       = 1'($urandom);
        b.rdst     = 3'($urandom);
        b.wf       = 1'($urandom);
        b.hi       = ($urandom_range(2) == 0);
        b.lo       = ($urandom_range(2) == 0);
        b.inn      = 1'($urandom);
        b.outn     = 1'($urandom);
        return b;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        out_t  z;
        z = '0;

        // Reset with random inputs, then release with an idle beat.
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            b = rand_beat(0, 30, 30);
            b.rst = 1'b1;
            drive(b);
            @(posedge clk); #1;
            check($sformatf("reset_%0d", i), 64'(get_out()), 64'(z));
        end
        drive(mkb(0, 0, 0, 16'h0, 16'h0, 0, 0, 3'd0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("reset_release", 64'(get_out()), 64'(z));

        // Directed sequence: mux, stall, flush, PC restore and error cases.
        tv.push_back('{mkb(0,0,1,16'h1234,16'hABCD,1,1,3'd5,0,0,0,0,0), mko(1,1,3'd5,16'hABCD,0,0,0,0,32'h0,0)});
        tv.push_back('{mkb(0,0,1,16'h1234,16'hABCD,0,1,3'd5,0,0,0,0,0), mko(1,1,3'd5,16'h1234,0,0,0,0,32'h0,0)});
        tv.push_back('{mkb(1,0,1,16'h1111,16'h0,0,0,3'd2,1,0,0,1,0), mko(1,1,3'd5,16'h1234,0,0,0,0,32'h0,0)});
        tv.push_back('{mkb(1,0,1,16'h2222,16'h0,0,1,3'd6,0,1,0,0,1), mko(1,1,3'd5,16'h1234,0,0,0,0,32'h0,0)});
        tv.push_back('{mkb(1,0,0,16'h3333,16'h0,0,1,3'd7,0,0,1,0,0), mko(1,1,3'd5,16'h1234,0,0,0,0,32'h0,0)});
        tv.push_back('{mkb(1,1,1,16'h4444,16'h0,0,1,3'd1,0,0,0,0,0), mko(0,0,3'd5,16'h1234,0,0,0,0,32'h0,0)});
        tv.push_back('{mkb(0,0,1,16'h0,16'h00AB,1,0,3'd0,0,1,0,0,0), mko(1,0,3'd0,16'h00AB,0,0,0,0,32'h0,0)});
        tv.push_back('{mkb(0,0,0,16'h0,16'h0,0,0,3'd0,0,0,0,0,0), mko(0,0,3'd0,16'h0,0,0,0,0,32'h0,0)});
        tv.push_back('{mkb(1,0,1,16'h0,16'hFFFF,1,0,3'd0,0,0,1,0,0), mko(0,0,3'd0,16'h0,0,0,0,0,32'h0,0)});
        tv.push_back('{mkb(0,0,1,16'h0,16'hCD00,1,0,3'd0,0,0,1,0,0), mko(1,0,3'd0,16'hCD00,0,0,0,1,32'h00ABCD00,0)});
        tv.push_back('{mkb(0,0,0,16'h0,16'h0,0,0,3'd0,0,0,0,0,0), mko(0,0,3'd0,16'h0,0,0,0,0,32'h00ABCD00,0)});
        tv.push_back('{mkb(0,0,1,16'h0,16'h0001,1,0,3'd0,0,0,1,0,0), mko(1,0,3'd0,16'h0001,0,0,0,0,32'h00ABCD00,1)});
        tv.push_back('{mkb(0,0,1,16'h0,16'h0002,1,0,3'd0,0,1,1,0,0), mko(1,0,3'd0,16'h0002,0,0,0,0,32'h00ABCD00,1)});
        tv.push_back('{mkb(0,0,1,16'h0,16'h0077,1,0,3'd0,0,1,0,0,0), mko(1,0,3'd0,16'h0077,0,0,0,0,32'h00ABCD00,0)});
        tv.push_back('{mkb(0,1,1,16'h0005,16'h0,0,1,3'd4,0,0,0,0,0), mko(0,0,3'd0,16'h0077,0,0,0,0,32'h00ABCD00,0)});
        tv.push_back('{mkb(0,0,1,16'h0,16'h0088,1,0,3'd0,0,0,1,0,0), mko(1,0,3'd0,16'h0088,0,0,0,0,32'h00ABCD00,1)});
        tv.push_back('{mkb(0,0,0,16'h0009,16'h0,0,1,3'd0,1,0,0,1,1), mko(0,0,3'd0,16'h0009,0,0,0,0,32'h00ABCD00,0)});
        tv.push_back('{mkb(0,0,1,16'h0042,16'h0,0,1,3'd3,1,0,0,1,1), mko(1,1,3'd3,16'h0042,1,1,1,0,32'h00ABCD00,0)});
        tv.push_back('{mkb(0,0,1,16'h0,16'h0011,1,0,3'd0,0,1,0,0,0), mko(1,0,3'd0,16'h0011,0,0,0,0,32'h00ABCD00,0)});
        tv.push_back('{mkb(0,0,1,16'h0,16'h0022,1,0,3'd0,0,1,0,0,0), mko(1,0,3'd0,16'h0022,0,0,0,0,32'h00ABCD00,1)});
        tv.push_back('{mkb(0,0,1,16'h0,16'h0033,1,0,3'd0,0,0,1,0,0), mko(1,0,3'd0,16'h0033,0,0,0,1,32'h00220033,0)});

        foreach (tv[i]) begin
            drive(tv[i].b);
            @(posedge clk); #1;
            check($sformatf("vec_%0d", i), 64'(get_out()), 64'(tv[i].e));
`ifdef MEM_WB_BYPASS_EN
            check($sformatf("fwd_%0d", i), 64'({bus.fwd_en, bus.fwd_rdst, bus.fwd_data}),
                  64'({tv[i].e.en, tv[i].e.rdst, tv[i].e.data}));
`endif
        end

        // Randomized beats against the reference model, starting from a reset.
        b = rand_beat(0, 0, 0);
        b.rst = 1'b1;
        drive(b);
        model_step(b);
        @(posedge clk); #1;
        check("rand_reset", 64'(get_out()), 64'(m));
        for (int i = 0; i < 600; i++) begin
            b = rand_beat(2, 15, 8);
            drive(b);
            model_step(b);
            @(posedge clk); #1;
            check($sformatf("rand_%0d", i), 64'(get_out()), 64'(m));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline boundary: registers memory-stage results and selects writeback data in the registered path.
- Adds valid tracking, stall (hold), flush (bubble insert), and a 2-beat PC-restore sequencer assembling a 2*DATA_W PC from high/low memory beats.
- Sits between data memory stage and register file / fetch PC-load logic.

Parameters:
- DATA_W, 16, datapath width of ALU and memory data.
- REG_ADDR_W, 3, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold all stage state.
- flush  in  1  squash stage contents; priority over stall.
- in_valid  in  1  incoming beat is a real instruction.
- alu_data_in  in  DATA_W  ALU result.
- mem_data_in  in  DATA_W  memory read data.
- mem_read_in  in  1  select memory data for writeback.
- wb_in  in  1  instruction writes register file.
- rdst_in  in  REG_ADDR_W  destination register.
- write_flag_in  in  1  instruction writes flags.
- write_pc_high_in  in  1  beat carries PC high half.
- write_pc_low_in  in  1  beat carries PC low half.
- in_inst_in  in  1  IN-port instruction marker.
- out_inst_in  in  1  OUT-port instruction marker.
- wb_valid  out  1  registered valid.
- wb_en  out  1  register-file write enable.
- wb_rdst  out  REG_ADDR_W  registered destination.
- wb_data  out  DATA_W  registered selected writeback data.
- write_flag_out  out  1  gated flag write.
- in_inst_out  out  1  gated IN marker.
- out_inst_out  out  1  gated OUT marker.
- pc_load  out  1  one-cycle PC-load pulse.
- pc_value  out  2*DATA_W  assembled PC {high, low}.
- pc_seq_err  out  1  one-cycle sequencing-error pulse.

Behaviour:
- Reset: all outputs 0, FSM IDLE, high-half holding register 0. Reset has priority over flush and stall.
- Accept = !rst & !flush & !stall & in_valid.
- Latency 1 cycle. On !stall & !flush: wb_valid<=in_valid; wb_data<=mem_read_in ? mem_data_in : alu_data_in; wb_rdst<=rdst_in. Control outputs (wb_en, write_flag_out, in_inst_out, out_inst_out) <= input & in_valid.
- Stall (no flush): every register, including FSM and pc_value, holds; pc_load and pc_seq_err forced 0 that cycle.
- Flush: wb_valid and all control outputs <= 0; FSM <= IDLE; data/rdst registers don't-care, held. Flush + stall in the same cycle = flush.
- PC FSM states IDLE, HAVE_HIGH; advances on accepted beats only. Bubbles never advance it.
  - IDLE, high only: hi_reg<=selected data, go to HAVE_HIGH.
  - IDLE, low only: pc_seq_err pulse, no load, stay IDLE.
  - HAVE_HIGH, low only: pc_value<={hi_reg, selected data}, pc_load pulse next cycle, go to IDLE.
  - HAVE_HIGH, high again: overwrite hi_reg, pc_seq_err pulse, stay HAVE_HIGH.
  - Any state, high & low in the same beat: pc_seq_err pulse, no load, go to IDLE.
- pc_load and pc_seq_err are registered single-cycle pulses aligned with that beat's wb_valid. pc_value holds its last value between loads.

Optional Feature:
- Macro MEM_WB_BYPASS_EN.
- Defined: adds outputs fwd_en (1), fwd_rdst (REG_ADDR_W), fwd_data (DATA_W), driven combinationally from the registered stage (fwd_en = wb_en), so execute-stage forwarding can use them.
- Undefined: these ports don't exist; no extra logic.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0. Release with in_valid=0 -> outputs remain 0.
- Mux/latency: in_valid=1, wb_in=1, rdst_in=5, alu=0x1234, mem=0xABCD, mem_read=1 -> next cycle wb_en=1, wb_rdst=5, wb_data=0xABCD. Same beat with mem_read=0 -> wb_data=0x1234.
- Stall/flush: stall=1 for 3 cycles with changing inputs -> outputs frozen. Flush=1 with stall=1 -> wb_valid=0, wb_en=0 next cycle.
- PC restore: accepted high beat mem=0x00AB, bubble, stall cycle, then low beat mem=0xCD00 -> single pc_load pulse with pc_value=0x00ABCD00, FSM back to IDLE.
- Errors: low with no prior high -> pc_seq_err=1, pc_load=0. High & low same beat -> pc_seq_err=1. High, flush, then low -> pc_seq_err=1, no load.
- MEM_WB_BYPASS_EN: write to r3 with 0x0042 -> fwd_en=1, fwd_rdst=3, fwd_data=0x0042 in the same cycle as wb_en.
